s_modred: RTL and testbench



---
 rtl/s_modred_if.sv | 33 +++
 rtl/s_modred.sv | 122 ++++++++++++
 tb/tb_s_modred.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/s_modred_if.sv
// Request/response bundle between the RSA multiplier side and the modular-reduction stage.
// The master drives the operands and start; the slave returns busy/done/R/err.
interface s_modred_if #(
    parameter int BIT = 8
);
    logic               start;
    logic [2*BIT-1:0]   P;
    logic [BIT-1:0]     N;
    logic               busy;
    logic               done;
    logic [BIT-1:0]     R;
    logic               err;

    modport master (
        output start,
        output P,
        output N,
        input  busy,
        input  done,
        input  R,
        input  err
    );

    modport slave (
        input  start,
        input  P,
        input  N,
        output busy,
        output done,
        output R,
        output err
    );
endinterface

// File: rtl/s_modred.sv
// Sequential R = P mod N by restoring shift-subtract, one SHIFT and one SUB cycle per dividend bit.
// Optional zero-modulus early exit is enabled by defining MODRED_ZCHK_EN.
module s_modred #(
    parameter int BIT  = 8,
    parameter int CNTW = 5
) (
    input  logic        clk,
    input  logic        rst,
    s_modred_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB
    } state_t;

    state_t             state, state_n;
    logic [2*BIT-1:0]   q, q_n;
    logic [BIT:0]       rem, rem_n;
    logic [BIT-1:0]     nreg, nreg_n;
    logic [CNTW-1:0]    cnt, cnt_n;
    logic [BIT-1:0]     r, r_n;
    logic               done, done_n;
    logic [BIT:0]       rem_sub;
    logic               rem_ge;
    logic               zero_start;

    // A single BIT+1-bit comparator/subtractor shared by every SUB step.
    assign rem_sub = rem - {1'b0, nreg};
    assign rem_ge  = (rem >= {1'b0, nreg});

`ifdef MODRED_ZCHK_EN
    logic err;

    assign zero_start = (bus.N == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            err <= zero_start;
        end
    end

    assign bus.err = err;
`else
    assign zero_start = 1'b0;
    assign bus.err    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        q_n     = q;
        rem_n   = rem;
        nreg_n  = nreg;
        cnt_n   = cnt;
        r_n     = r;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (zero_start) begin
                        r_n    = '0;
                        done_n = 1'b1;
                    end else begin
                        q_n     = bus.P;
                        nreg_n  = bus.N;
                        rem_n   = '0;
                        cnt_n   = CNTW'(2 * BIT);
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                rem_n   = {rem[BIT-1:0], q[2*BIT-1]};
                q_n     = {q[2*BIT-2:0], 1'b0};
                state_n = SUB;
            end
            SUB: begin
                if (rem_ge) begin
                    rem_n = rem_sub;
                end
                cnt_n = cnt - CNTW'(1);
                // Last iteration: the post-subtract remainder is already below nreg.
                if (cnt == CNTW'(1)) begin
                    r_n     = rem_ge ? rem_sub[BIT-1:0] : rem[BIT-1:0];
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = SHIFT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            rem   <= '0;
            nreg  <= '0;
            cnt   <= '0;
            r     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            rem   <= rem_n;
            nreg  <= nreg_n;
            cnt   <= cnt_n;
            r     <= r_n;
            done  <= done_n;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done;
    assign bus.R    = r;
endmodule

// File: tb/tb_s_modred.sv
// Directed bench for s_modred (BIT=8): a vector table of hand-computed remainders plus
// sequences for mid-operation reset, start while busy and back-to-back operation.
module tb_s_modred;
    localparam int BIT  = 8;
    localparam int CNTW = 5;
    localparam int NVEC = 12;

    typedef struct {
        logic [2*BIT-1:0] p;
        logic [BIT-1:0]   n;
        logic [BIT-1:0]   r;
        logic             err;
        int               lat;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs [NVEC];

    s_modred_if #(.BIT(BIT)) bus ();

    s_modred #(
        .BIT  (BIT),
        .CNTW (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one start pulse and waits (bounded) for done; returns edges from start sample to done.
    task automatic apply_stimulus(input logic [2*BIT-1:0] p, input logic [BIT-1:0] n,
                                  output int lat, output int busy_cnt, output logic r_moved);
        logic [BIT-1:0] r0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.P     = p;
        bus.N     = n;
        r0        = bus.R;
        @(negedge clk);
        bus.start = 1'b0;
        bus.P     = 16'($urandom);
        bus.N     = 8'($urandom_range(1, 255));
        lat       = 1;
        busy_cnt  = 0;
        r_moved   = 1'b0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) busy_cnt++;
            if (bus.R !== r0) r_moved = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   bcnt;
        int   gap;
        logic moved;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.P     = '0;
        bus.N     = '0;

        vecs[0]  = '{p: 16'd50000, n: 8'd97,  r: 8'd45,  err: 1'b0, lat: 33};
        vecs[1]  = '{p: 16'hFFFF,  n: 8'd255, r: 8'd0,   err: 1'b0, lat: 33};
        vecs[2]  = '{p: 16'd12345, n: 8'd200, r: 8'd145, err: 1'b0, lat: 33};
        vecs[3]  = '{p: 16'd0,     n: 8'd13,  r: 8'd0,   err: 1'b0, lat: 33};
        vecs[4]  = '{p: 16'd40000, n: 8'd1,   r: 8'd0,   err: 1'b0, lat: 33};
        vecs[5]  = '{p: 16'd65025, n: 8'd251, r: 8'd16,  err: 1'b0, lat: 33};
`ifdef MODRED_ZCHK_EN
        vecs[6]  = '{p: 16'd1234,  n: 8'd0,   r: 8'd0,   err: 1'b1, lat: 1};
`else
        vecs[6]  = '{p: 16'd1234,  n: 8'd0,   r: 8'hD2,  err: 1'b0, lat: 33};
`endif
        vecs[7]  = '{p: 16'd1000,  n: 8'd7,   r: 8'd6,   err: 1'b0, lat: 33};
        vecs[8]  = '{p: 16'hFFFF,  n: 8'd128, r: 8'd127, err: 1'b0, lat: 33};
        vecs[9]  = '{p: 16'd254,   n: 8'd255, r: 8'd254, err: 1'b0, lat: 33};
        vecs[10] = '{p: 16'd255,   n: 8'd16,  r: 8'd15,  err: 1'b0, lat: 33};
        vecs[11] = '{p: 16'd300,   n: 8'd255, r: 8'd45,  err: 1'b0, lat: 33};

        repeat (3) @(negedge clk);
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_done", bus.done, 0);
        check_output("reset_R",    bus.R,    0);
        check_output("reset_err",  bus.err,  0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].p, vecs[i].n, lat, bcnt, moved);
            check_output($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check_output($sformatf("v%0d_R", i), bus.R, vecs[i].r);
            check_output($sformatf("v%0d_err", i), bus.err, vecs[i].err);
            check_output($sformatf("v%0d_busy_at_done", i), bus.busy, 0);
            check_output($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat - 1);
            check_output($sformatf("v%0d_R_held", i), moved, 0);
            @(negedge clk);
            check_output($sformatf("v%0d_done_pulse", i), bus.done, 0);
        end

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        bus.start = 1'b1;
        bus.P     = 16'd50000;
        bus.N     = 8'd97;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check_output("midrst_busy_before", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst_busy", bus.busy, 0);
        check_output("midrst_done", bus.done, 0);
        check_output("midrst_R",    bus.R,    0);
        apply_stimulus(16'd50000, 8'd97, lat, bcnt, moved);
        check_output("midrst_rerun_latency", lat, 33);
        check_output("midrst_rerun_R", bus.R, 45);

        // A second start during an operation is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.P     = 16'd12345;
        bus.N     = 8'd200;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b1;
        bus.P     = 16'd50000;
        bus.N     = 8'd97;
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_output("busy_start_latency", lat, 33);
        check_output("busy_start_R", bus.R, 145);
        @(negedge clk);
        check_output("busy_start_no_relaunch", bus.busy, 0);

        // Start held high: operations run back to back.
        bus.start = 1'b1;
        bus.P     = 16'd1000;
        bus.N     = 8'd7;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.done && gap < 200);
        check_output("hold_first_done", bus.done, 1);
        check_output("hold_first_R", bus.R, 6);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.done && gap < 200);
        bus.start = 1'b0;
        check_output("hold_done_spacing", gap, 33);
        check_output("hold_second_R", bus.R, 6);
        @(negedge clk);
        check_output("hold_stop_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end
endmodule
